tick_counter_4bit: RTL and testbench
====================================

TICK_COUNTER_4BIT -- requirements
Module: tick_counter_4bit

Interface
REQ-001 SHALL have parameter DIV_MAX, default 49999999, meaning terminal count of the internal rate divider (tick period = DIV_MAX+1 clocks; 1 Hz at 50 MHz).
REQ-002 SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-004 SHALL have port load, input, 1, load load_val into value.
REQ-005 SHALL have port load_val, input, 4, value to load (typically from SW[3:0]).
REQ-006 SHALL have port start, input, 1, enter RUNNING.
REQ-007 SHALL have port stop, input, 1, enter STOPPED.
REQ-008 SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-009 SHALL have port value, output, 4, registered count; drives the downstream binary-to-BCD two-digit display stage directly.
REQ-010 SHALL have port tick, output, 1, one-cycle pulse coincident with each new value from counting.
REQ-011 SHALL have port wrap, output, 1, one-cycle pulse coincident with a 15->0 or 0->15 transition.
REQ-012 SHALL have port running, output, 1, high while in RUNNING.

Function
REQ-013 SHALL implement two states, STOPPED and RUNNING; start moves STOPPED->RUNNING, stop moves RUNNING->STOPPED.
REQ-014 SHALL give priority load > stop > start when asserted in the same cycle.
REQ-015 SHALL ignore start while RUNNING (divider not restarted) and stop while STOPPED.
REQ-016 SHALL count the divider 0..DIV_MAX only in RUNNING, assert internal tick_en for the cycle divider==DIV_MAX, then return to 0.
REQ-017 SHALL hold the divider at 0 in STOPPED and clear it to 0 on load; a stop/start pair restarts the full period.
REQ-018 SHALL, on the edge ending a tick_en cycle, update value by +1 (up=1) or -1 (up=0) modulo 16, and assert tick for exactly the following cycle.
REQ-019 SHALL assert wrap with tick when value goes 15->0 (up) or 0->15 (down).
REQ-020 SHALL sample up only in the tick_en cycle; changes mid-period take effect at the next tick.
REQ-021 SHALL, on load, set value=load_val on the next edge with tick=0 and wrap=0, even if tick_en coincides; state unchanged.
REQ-022 SHALL, with DIV_MAX=0, produce tick_en every RUNNING cycle.
REQ-023 SHALL register all outputs; no combinational path from any input to any output.

Reset
REQ-024 SHALL, on a clock edge with resetn=0, set value=0, state=STOPPED, divider=0, tick=0, wrap=0, running=0, with priority over all other inputs.
REQ-025 SHALL discard any partial divider period when reset is asserted mid-operation.

Configuration
REQ-026 SHALL, with TICK_COUNTER_SATURATE_EN defined, hold value at 15 (up) or 0 (down) instead of wrapping, suppress tick and wrap for that step, and transition to STOPPED.
REQ-027 SHALL, without TICK_COUNTER_SATURATE_EN, wrap modulo 16 per REQ-018/REQ-019 and never stop itself.

Structure
REQ-028 SHALL place state encoding (STOPPED=0, RUNNING=1) and the 4-bit value width constant in package tick_counter_pkg.
REQ-029 SHALL implement the divider as sub-module rate_divider (inputs clock, resetn, clear, enable; output tick_en; parameter DIV_MAX).

Verification (DIV_MAX=3 unless stated)
REQ-030 SHALL cover: reset, start, up=1 -> tick every 4 clocks, value 0,1,2,...; 15->0 step asserts tick and wrap together.
REQ-031 SHALL cover: load with load_val=9, up=0, start -> 8,7,...,0, then 15 with wrap=1 (saturating build: holds 0, running=0, no tick).
REQ-032 SHALL cover: load=1 in the same cycle as tick_en, load_val=5 -> value=5, tick=0, wrap=0, next tick 4 clocks later.
REQ-033 SHALL cover: start and stop in the same cycle from STOPPED -> running stays 0; stop at divider=2 then start -> next tick a full 4 clocks after start.
REQ-034 SHALL cover: resetn=0 for one cycle while RUNNING at value=7 -> value=0, running=0, tick=0 next cycle; DIV_MAX=0 build ticks every cycle.

Source files
------------

// File: rtl/tick_counter_pkg.sv
// rtl/tick_counter_pkg.sv - shared state encoding, value width and count-step helper
package tick_counter_pkg;

    localparam int VALUE_W = 4;
    localparam logic [VALUE_W-1:0] VALUE_MAX = '1;
    localparam logic [VALUE_W-1:0] VALUE_MIN = '0;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    typedef struct packed {
        logic [VALUE_W-1:0] value;
        logic               wrap;
    } step_t;

    // One modulo-16 step in the requested direction; wrap flags the boundary crossing.
    function automatic step_t count_step(input logic [VALUE_W-1:0] cur, input logic up);
        step_t s;
        if (up) begin
            s.value = cur + VALUE_W'(1);
            s.wrap  = (cur == VALUE_MAX);
        end else begin
            s.value = cur - VALUE_W'(1);
            s.wrap  = (cur == VALUE_MIN);
        end
        return s;
    endfunction

endpackage

// File: rtl/tick_counter_rate_divider.sv
// rtl/tick_counter_rate_divider.sv - free-running 0..DIV_MAX divider producing tick_en
module rate_divider #(
    parameter int DIV_MAX = 49999999
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tick_en
);

    localparam int CNT_W = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_MAX);

    logic [CNT_W-1:0] count;

    // Held at zero whenever disabled so every restart begins a full period.
    always_ff @(posedge clock) begin
        if (!resetn || clear || !enable) begin
            count <= '0;
        end else if (count == CNT_MAX) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick_en = enable && (count == CNT_MAX);

endmodule

// File: rtl/tick_counter_4bit.sv
// rtl/tick_counter_4bit.sv - start/stop 4-bit up/down tick counter; TICK_COUNTER_SATURATE_EN selects saturate-and-stop
module tick_counter_4bit
    import tick_counter_pkg::*;
#(
    parameter int DIV_MAX = 49999999
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               load,
    input  logic [VALUE_W-1:0] load_val,
    input  logic               start,
    input  logic               stop,
    input  logic               up,
    output logic [VALUE_W-1:0] value,
    output logic               tick,
    output logic               wrap,
    output logic               running
);

    state_t             state;
    state_t             state_nxt;
    logic [VALUE_W-1:0] value_nxt;
    logic               tick_nxt;
    logic               wrap_nxt;
    logic               tick_en;
    step_t              step;

    rate_divider #(
        .DIV_MAX (DIV_MAX)
    ) u_rate_divider (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (load),
        .enable  (state == RUNNING),
        .tick_en (tick_en)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= STOPPED;
        end else begin
            state <= state_nxt;
        end
    end

    // Load owns the cycle: it swallows start/stop and any coincident tick.
    always_comb begin
        state_nxt = state;
        value_nxt = value;
        tick_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        step      = count_step(value, up);
        if (load) begin
            value_nxt = load_val;
        end else begin
            if (stop) begin
                state_nxt = STOPPED;
            end else if (start) begin
                state_nxt = RUNNING;
            end
            if (tick_en) begin
`ifdef TICK_COUNTER_SATURATE_EN
                if (step.wrap) begin
                    state_nxt = STOPPED;
                end else begin
                    value_nxt = step.value;
                    tick_nxt  = 1'b1;
                end
`else
                value_nxt = step.value;
                tick_nxt  = 1'b1;
                wrap_nxt  = step.wrap;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            value   <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            running <= 1'b0;
        end else begin
            value   <= value_nxt;
            tick    <= tick_nxt;
            wrap    <= wrap_nxt;
            running <= (state_nxt == RUNNING);
        end
    end

endmodule

// File: tb/tb_tick_counter_4bit.sv
// tb/tb_tick_counter_4bit.sv - scoreboard bench for tick_counter_4bit (DIV_MAX=3 and DIV_MAX=0)
module tb_tick_counter_4bit;

    logic       clock = 1'b0;
    logic       resetn;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       stop;
    logic       up;
    logic [3:0] value;
    logic       tick;
    logic       wrap;
    logic       running;
    logic [3:0] value_f;
    logic       tick_f;
    logic       wrap_f;
    logic       running_f;

    typedef struct packed {
        logic [3:0] value;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    always #5 clock = ~clock;

    tick_counter_4bit #(.DIV_MAX(3)) dut (
        .clock(clock), .resetn(resetn), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .up(up),
        .value(value), .tick(tick), .wrap(wrap), .running(running)
    );

    tick_counter_4bit #(.DIV_MAX(0)) dut_fast (
        .clock(clock), .resetn(resetn), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .up(up),
        .value(value_f), .tick(tick_f), .wrap(wrap_f), .running(running_f)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_tick(output int n, output logic seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 12) begin
            cyc();
            n++;
            if (tick === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic drain_sb(input string tag);
        exp_t e;
        int   n;
        logic seen;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(n, seen);
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL %s_timeout got=no_tick want=value_%0d", tag, e.value);
                sb.delete();
            end else begin
                total++;
                if (n !== 4) begin bad++; $display("FAIL %s_period got=%0d want=4", tag, n); end
                total++;
                if (value !== e.value) begin bad++; $display("FAIL %s_value got=%0d want=%0d", tag, value, e.value); end
                total++;
                if (wrap !== e.wrap) begin bad++; $display("FAIL %s_wrap got=%0b want=%0b at value %0d", tag, wrap, e.wrap, e.value); end
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc();
        cyc();
        total++;
        if ({value, tick, wrap, running} !== 7'b0) begin
            bad++;
            $display("FAIL reset_state got=%0d/%0b/%0b/%0b want=0/0/0/0", value, tick, wrap, running);
        end
        resetn = 1'b1;
    endtask

    task automatic test_count_up();
        exp_t e;
        int   last;
        up = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        total++;
        if (running !== 1'b1) begin bad++; $display("FAIL up_running got=%0b want=1", running); end
`ifdef TICK_COUNTER_SATURATE_EN
        last = 15;
`else
        last = 16;
`endif
        for (int k = 1; k <= last; k++) begin
            e.value = 4'(k);
            e.wrap  = (k == 16);
            sb.push_back(e);
        end
        drain_sb("up");
`ifdef TICK_COUNTER_SATURATE_EN
        for (int k = 0; k < 8; k++) begin
            cyc();
            total++;
            if (tick !== 1'b0) begin bad++; $display("FAIL up_sat_tick got=%0b want=0", tick); end
        end
        total++;
        if (value !== 4'd15 || running !== 1'b0) begin
            bad++;
            $display("FAIL up_sat_hold got=%0d/%0b want=15/0", value, running);
        end
`else
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL up_stop got=%0b want=0", running); end
`endif
    endtask

    task automatic test_count_down();
        exp_t e;
        load_val = 4'd9;
        load = 1'b1;
        cyc();
        load = 1'b0;
        total++;
        if (value !== 4'd9 || tick !== 1'b0) begin
            bad++;
            $display("FAIL down_load got=%0d/%0b want=9/0", value, tick);
        end
        up = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 8; k >= 0; k--) begin
            e.value = 4'(k);
            e.wrap  = 1'b0;
            sb.push_back(e);
        end
`ifndef TICK_COUNTER_SATURATE_EN
        e.value = 4'd15;
        e.wrap  = 1'b1;
        sb.push_back(e);
`endif
        drain_sb("down");
`ifdef TICK_COUNTER_SATURATE_EN
        for (int k = 0; k < 8; k++) begin
            cyc();
            total++;
            if (tick !== 1'b0) begin bad++; $display("FAIL down_sat_tick got=%0b want=0", tick); end
        end
        total++;
        if (value !== 4'd0 || running !== 1'b0) begin
            bad++;
            $display("FAIL down_sat_hold got=%0d/%0b want=0/0", value, running);
        end
`else
        stop = 1'b1;
        cyc();
        stop = 1'b0;
`endif
    endtask

    task automatic test_load_on_tick();
        exp_t e;
        int   n;
        logic seen;
        up = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        cyc();
        load_val = 4'd5;
        load = 1'b1;
        cyc();
        load = 1'b0;
        total++;
        if (value !== 4'd5 || tick !== 1'b0 || wrap !== 1'b0 || running !== 1'b1) begin
            bad++;
            $display("FAIL collide_load got=%0d/%0b/%0b/%0b want=5/0/0/1", value, tick, wrap, running);
        end
        e.value = 4'd6;
        e.wrap  = 1'b0;
        sb.push_back(e);
        wait_tick(n, seen);
        e = sb.pop_front();
        total++;
        if (!seen || n !== 4 || value !== e.value) begin
            bad++;
            $display("FAIL collide_next got=seen%0b/n%0d/%0d want=seen1/n4/%0d", seen, n, value, e.value);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic test_start_stop();
        int   n;
        logic seen;
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL startstop_same got=%0b want=0", running); end
        load_val = 4'd2;
        load = 1'b1;
        cyc();
        load = 1'b0;
        up = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        cyc();
        total++;
        if (running !== 1'b0 || value !== 4'd2 || tick !== 1'b0) begin
            bad++;
            $display("FAIL midstop got=%0b/%0d/%0b want=0/2/0", running, value, tick);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_tick(n, seen);
        total++;
        if (!seen || n !== 4 || value !== 4'd3) begin
            bad++;
            $display("FAIL restart_period got=seen%0b/n%0d/%0d want=seen1/n4/3", seen, n, value);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int   n;
        logic seen;
        load_val = 4'd7;
        load = 1'b1;
        cyc();
        load = 1'b0;
        up = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        total++;
        if (value !== 4'd7 || running !== 1'b1) begin
            bad++;
            $display("FAIL prereset got=%0d/%0b want=7/1", value, running);
        end
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        total++;
        if (value !== 4'd0 || running !== 1'b0 || tick !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL midreset got=%0d/%0b/%0b/%0b want=0/0/0/0", value, running, tick, wrap);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_tick(n, seen);
        total++;
        if (!seen || n !== 4 || value !== 4'd1) begin
            bad++;
            $display("FAIL postreset_period got=seen%0b/n%0d/%0d want=seen1/n4/1", seen, n, value);
        end
    endtask

    task automatic test_div_zero();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        up = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            total++;
            if (tick_f !== 1'b1 || value_f !== 4'(k)) begin
                bad++;
                $display("FAIL div0_tick got=%0b/%0d want=1/%0d", tick_f, value_f, k);
            end
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        load = 1'b0;
        load_val = 4'd0;
        start = 1'b0;
        stop = 1'b0;
        up = 1'b1;
        test_reset();
        test_count_up();
        test_count_down();
        test_load_on_tick();
        test_start_stop();
        test_reset_mid_run();
        test_div_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
